line_buffer_nline: RTL and testbench

- Parametrised multi-line video line buffer. Successor to the single-port line RAM stub.
- Accepts a raster pixel stream and emits a vertically aligned column of NUM_LINES pixels per input pixel: the current line plus the NUM_LINES-1 previous lines at the same column.
- Sits between the camera/HDMI capture front-end and the windowed filters (erode/dilate, 3x3 convolution).
- Tracks line fill state, measures line length and flags overlong lines.

---
 rtl/line_buf_pkg.sv | 26 ++
 rtl/line_ram_sdp.sv | 26 ++
 rtl/line_buffer_nline.sv | 164 ++++++++++++++++
 tb/tb_line_buffer_nline.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// Shared types, constants and helpers for the multi-line video line buffer.
package line_buf_pkg;

  localparam int MAX_NUM_LINES      = 8;
  localparam int DEFAULT_DATA_WIDTH = 24;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

  // Returns at least 1 so a depth of 1 still gets a usable address bit.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int tap_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/line_ram_sdp.sv
// Simple-dual-port line RAM: one write port, one registered read port (1-cycle latency).
module line_ram_sdp #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_buffer_nline.sv
// Multi-line raster line buffer emitting NUM_LINES vertically aligned taps per pixel.
// Optional LINE_BUF_BORDER_REPLICATE_EN: unfilled taps replicate the oldest stored line instead of 0.
module line_buffer_nline
  import line_buf_pkg::*;
#(
  parameter int  DATA_WIDTH = 24,
  parameter int  LINE_DEPTH = 2048,
  parameter int  NUM_LINES  = 3,
  localparam int ADDR_WIDTH = clog2(LINE_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_sof,
  input  logic                            in_de,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            out_valid,
  output logic [NUM_LINES*DATA_WIDTH-1:0] out_taps,
  output logic [ADDR_WIDTH-1:0]           out_col,
  output logic                            out_line_ready,
  output logic                            out_overflow
);

  localparam int RAM_W  = (NUM_LINES - 1) * DATA_WIDTH;
  localparam int TAPS_W = NUM_LINES * DATA_WIDTH;
  localparam int LC_W   = clog2(MAX_NUM_LINES);
  localparam logic [LC_W-1:0]       LC_MAX   = LC_W'(NUM_LINES - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(LINE_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] col_q, col_d, rd_addr;
  logic                  line_full_q, line_full_d;
  logic                  de_prev_q;
  logic [LC_W-1:0]       line_cnt_q, line_cnt_d, lc_eff;
  logic                  overflow_q, overflow_d;
  logic                  line_ready_q, line_ready_d;
  logic                  accept;

  logic                  vld1_q, vld1_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [ADDR_WIDTH-1:0] col1_q, col1_d;
  logic [LC_W-1:0]       lc1_q, lc1_d;

  logic                  vld2_q, vld2_d;
  logic [TAPS_W-1:0]     taps_q, taps_d;
  logic [ADDR_WIDTH-1:0] out_col_q, out_col_d;

  logic [RAM_W-1:0]      rd_data;
  logic [TAPS_W-1:0]     col_full, col_masked;

  // Column pointer, line counter and frame-level flags; sof overrides everything.
  always_comb begin
    col_d       = col_q;
    line_full_d = line_full_q;
    line_cnt_d  = line_cnt_q;
    overflow_d  = overflow_q;
    accept      = 1'b0;
    rd_addr     = col_q;
    lc_eff      = line_cnt_q;
    if (in_sof) begin
      line_cnt_d  = '0;
      overflow_d  = 1'b0;
      line_full_d = 1'b0;
      lc_eff      = '0;
      rd_addr     = '0;
      accept      = in_de;
      col_d       = in_de ? ADDR_WIDTH'(1) : '0;
    end else if (in_de) begin
      if (line_full_q) begin
        overflow_d = 1'b1;
      end else begin
        accept = 1'b1;
        if (col_q == COL_LAST) line_full_d = 1'b1;
        else                   col_d = col_q + ADDR_WIDTH'(1);
      end
    end else begin
      col_d       = '0;
      line_full_d = 1'b0;
      if (de_prev_q && (line_cnt_q != LC_MAX)) line_cnt_d = line_cnt_q + LC_W'(1);
    end
    line_ready_d = (line_cnt_d == LC_MAX);
  end

  // S1: issue the RAM read and capture the pixel alongside it.
  always_comb begin
    vld1_d  = accept;
    data1_d = in_data;
    col1_d  = rd_addr;
    lc1_d   = lc_eff;
  end

  line_ram_sdp #(
    .WIDTH (RAM_W),
    .DEPTH (LINE_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (vld1_q),
    .waddr (col1_q),
    .wdata (col_full[RAM_W-1:0]),
    .re    (accept),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // S2: shift the column by one line on write-back and emit the masked taps.
  always_comb begin
    int lsb_k;
    int lsb_src;
    col_full   = {rd_data, data1_q};
    col_masked = col_full;
    lsb_src    = tap_lsb(int'(lc1_q), DATA_WIDTH);
    for (int k = 1; k < NUM_LINES; k++) begin
      lsb_k = tap_lsb(k, DATA_WIDTH);
      if (int'(lc1_q) < k) begin
`ifdef LINE_BUF_BORDER_REPLICATE_EN
        col_masked[lsb_k +: DATA_WIDTH] = col_full[lsb_src +: DATA_WIDTH];
`else
        col_masked[lsb_k +: DATA_WIDTH] = '0;
`endif
      end
    end
    vld2_d    = vld1_q;
    taps_d    = vld1_q ? col_masked : taps_q;
    out_col_d = vld1_q ? col1_q : out_col_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      line_full_q  <= 1'b0;
      de_prev_q    <= 1'b0;
      line_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      line_ready_q <= 1'b0;
      vld1_q       <= 1'b0;
      vld2_q       <= 1'b0;
      taps_q       <= '0;
      out_col_q    <= '0;
    end else begin
      col_q        <= col_d;
      line_full_q  <= line_full_d;
      de_prev_q    <= in_de;
      line_cnt_q   <= line_cnt_d;
      overflow_q   <= overflow_d;
      line_ready_q <= line_ready_d;
      vld1_q       <= vld1_d;
      vld2_q       <= vld2_d;
      taps_q       <= taps_d;
      out_col_q    <= out_col_d;
    end
  end

  always_ff @(posedge clk) begin
    data1_q <= data1_d;
    col1_q  <= col1_d;
    lc1_q   <= lc1_d;
  end

  assign out_valid      = vld2_q;
  assign out_taps       = taps_q;
  assign out_col        = out_col_q;
  assign out_line_ready = line_ready_q;
  assign out_overflow   = overflow_q;

endmodule

// File: tb/tb_line_buffer_nline.sv
// Bench for line_buffer_nline: a 3-line and a 5-line instance share one pixel stream.
module tb_line_buffer_nline;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_sof, in_de;
  logic [DW-1:0] in_data;

  logic          v3, rdy3, ovf3;
  logic [3*DW-1:0] taps3;
  logic [AW-1:0] col3;
  logic          v5, rdy5, ovf5;
  logic [5*DW-1:0] taps5;
  logic [AW-1:0] col5;

  line_buffer_nline #(.DATA_WIDTH(DW), .LINE_DEPTH(DEPTH), .NUM_LINES(3)) u_dut3 (
    .clk(clk), .rst(rst_n), .in_sof(in_sof), .in_de(in_de), .in_data(in_data),
    .out_valid(v3), .out_taps(taps3), .out_col(col3),
    .out_line_ready(rdy3), .out_overflow(ovf3));

  line_buffer_nline #(.DATA_WIDTH(DW), .LINE_DEPTH(DEPTH), .NUM_LINES(5)) u_dut5 (
    .clk(clk), .rst(rst_n), .in_sof(in_sof), .in_de(in_de), .in_data(in_data),
    .out_valid(v5), .out_taps(taps5), .out_col(col5),
    .out_line_ready(rdy5), .out_overflow(ovf5));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  typedef struct {
    int              due;
    logic [AW-1:0]   col;
    logic [3*DW-1:0] t3;
    logic [5*DW-1:0] t5;
  } exp_t;

  exp_t q[$];

  // Reference model: whole frame kept as a 2-D picture, taps looked up by line index.
  logic [DW-1:0] frame_px [0:127][0:DEPTH-1];
  int m_line = 0;
  int m_pix  = 0;
  bit m_prev = 1'b0;
  bit m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] tap_val(input int line, input int col, input int k);
    if (line >= k) return frame_px[line-k][col];
`ifdef LINE_BUF_BORDER_REPLICATE_EN
    return frame_px[0][col];
`else
    return '0;
`endif
  endfunction

  task automatic model_step(input bit sof, input bit de, input logic [DW-1:0] d);
    int   c;
    bit   acc;
    exp_t e;
    acc = 1'b0;
    c   = 0;
    if (sof) begin
      m_line = 0; m_pix = 0; m_ovf = 1'b0;
    end else if (!de && m_prev) begin
      m_line++;
    end
    if (de) begin
      if (m_pix < DEPTH) begin acc = 1'b1; c = m_pix; end
      else m_ovf = 1'b1;
      m_pix++;
    end else begin
      m_pix = 0;
    end
    m_prev = de;
    if (acc) begin
      frame_px[m_line][c] = d;
      e.due = cyc + 2;
      e.col = AW'(c);
      e.t3  = '0;
      e.t5  = '0;
      for (int k = 0; k < 3; k++) e.t3[k*DW +: DW] = tap_val(m_line, c, k);
      for (int k = 0; k < 5; k++) e.t5[k*DW +: DW] = tap_val(m_line, c, k);
      q.push_back(e);
    end
  endtask

  task automatic drive(input bit sof, input bit de, input logic [DW-1:0] d);
    in_sof = sof; in_de = de; in_data = d;
    model_step(sof, de, d);
    @(posedge clk); #1;
    chk("line_ready3", rdy3, (m_line >= 2));
    chk("line_ready5", rdy5, (m_line >= 4));
    chk("overflow3", ovf3, m_ovf);
    chk("overflow5", ovf5, m_ovf);
  endtask

  task automatic send_line(input bit sof_first, input int len, input int gap,
                           input int line_idx, input bit rnd);
    for (int c = 0; c < len; c++)
      drive(sof_first && (c == 0), 1'b1, rnd ? DW'($urandom) : DW'(line_idx*16 + c));
    for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid3"}, v3, 0);
    chk({tag, "_valid5"}, v5, 0);
    chk({tag, "_taps3"}, taps3, 0);
    chk({tag, "_taps5"}, taps5, 0);
    chk({tag, "_col3"}, col3, 0);
    chk({tag, "_col5"}, col5, 0);
    chk({tag, "_ready3"}, rdy3, 0);
    chk({tag, "_ready5"}, rdy5, 0);
    chk({tag, "_ovf3"}, ovf3, 0);
    chk({tag, "_ovf5"}, ovf5, 0);
  endtask

  always @(negedge clk) begin : mon
    bit   ev;
    exp_t e;
    if (!rst_n) begin
      chk("valid_in_reset3", v3, 0);
      chk("valid_in_reset5", v5, 0);
    end else begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid3", v3, ev);
      chk("out_valid5", v5, ev);
      if (ev) begin
        e = q.pop_front();
        chk("out_col3", col3, e.col);
        chk("out_col5", col5, e.col);
        chk("out_taps3", taps3, e.t3);
        chk("out_taps5", taps5, e.t5);
      end
    end
  end

  initial begin
    int len, nl, gap;
    in_sof = 1'b0; in_de = 1'b0; in_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);

    // Three lines of 8 pixels, value line*16+col.
    send_line(1'b1, 8, 3, 0, 1'b0);
    send_line(1'b0, 8, 3, 1, 1'b0);
    send_line(1'b0, 8, 3, 2, 1'b0);

    // New frame, line 0 only: stale RAM from the previous frame must not show.
    send_line(1'b1, 8, 3, 7, 1'b0);

    // Overlong line: 20 pixels into a 16-deep buffer, overflow held until next sof.
    send_line(1'b1, 20, 4, 3, 1'b0);
    repeat (5) drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, '0);

    // Five lines, then sof coincident with the first pixel of the next frame.
    for (int l = 0; l < 5; l++) send_line(l == 0, 8, 2, l, 1'b0);
    send_line(1'b1, 8, 2, 9, 1'b0);

    // Reset mid-line with column 3 sitting in the first stage.
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b1, DW'(8'hA0 + c));
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    q.delete();
    m_line = 0; m_pix = 0; m_prev = 1'b0; m_ovf = 1'b0;
    in_de = 1'b0; in_sof = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back lines with a 1-cycle gap; 5-line instance saturates.
    for (int l = 0; l < 7; l++) send_line(1'b0, 10, 1, l, 1'b1);

    // Random frames: constant line length within a frame, random gaps and data.
    for (int f = 0; f < 5; f++) begin
      len = $urandom_range(1, DEPTH);
      nl  = $urandom_range(1, 9);
      for (int l = 0; l < nl; l++) begin
        gap = $urandom_range(1, 3);
        send_line(l == 0, len, gap, l, 1'b1);
      end
    end

    repeat (5) drive(1'b0, 1'b0, '0);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
